// File: rtl/lcd_spi_master.sv
// 4-wire SPI master for the LCD panel: command FIFO, MSB-first shifter with a
// programmable SCL half-period, CS held low across bursts, panel reset/backlight pins.
module lcd_spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_rs,
    input  logic                          in_last,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [DIV_WIDTH-1:0]          div,
    input  logic                          lcd_rst_req,
    input  logic                          led_en,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          rst_lcd,
    output logic                          scl_lcd,
    output logic                          sda_lcd,
    output logic                          cs_lcd,
    output logic                          rs_lcd,
    output logic                          led_lcd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int EW = DATA_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    logic [EW-1:0]         mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [LW-1:0]         count_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [EW-1:0]         head_s;
    logic                  head_rs_s;
    logic                  head_last_s;
    logic [DATA_WIDTH-1:0] head_data_s;

    state_t                state_r, state_s;
    logic [DIV_WIDTH-1:0]  ph_r, ph_s;
    logic [DIV_WIDTH-1:0]  hdiv_r, hdiv_s;
    logic [BW-1:0]         bit_r, bit_s;
    logic [DATA_WIDTH-1:0] sh_r, sh_s;
    logic                  last_r, last_s;
    logic                  cs_r, cs_s;
    logic                  scl_r, scl_s;
    logic                  sda_r, sda_s;
    logic                  rs_r, rs_s;
    logic                  done_r, done_s;
    logic                  rst_lcd_r;
    logic                  led_lcd_r;
    logic                  phase_end_s;

    // FIFO status; in_ready depends only on fill level, never on a same-cycle pop
    always_comb begin
        full_s      = (count_r == LW'(FIFO_DEPTH));
        empty_s     = (count_r == {LW{1'b0}});
        push_s      = in_valid & ~full_s;
        head_s      = mem_r[rd_ptr_r];
        head_rs_s   = head_s[EW-1];
        head_last_s = head_s[EW-2];
        head_data_s = head_s[DATA_WIDTH-1:0];
    end

    // FIFO storage, entry layout {rs, last, data}
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_rs, in_last, in_data};
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign phase_end_s = (ph_r == hdiv_r);

    // Next-state and next-pin logic; pins are registered together with the state
    always_comb begin
        state_s = state_r;
        ph_s    = ph_r + DIV_WIDTH'(1);
        hdiv_s  = hdiv_r;
        bit_s   = bit_r;
        sh_s    = sh_r;
        last_s  = last_r;
        cs_s    = cs_r;
        scl_s   = scl_r;
        sda_s   = sda_r;
        rs_s    = rs_r;
        done_s  = 1'b0;
        pop_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                ph_s  = {DIV_WIDTH{1'b0}};
                cs_s  = 1'b1;
                scl_s = 1'b1;
                sda_s = 1'b1;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    sh_s    = head_data_s;
                    last_s  = head_last_s;
                    hdiv_s  = div;
                    rs_s    = head_rs_s;
                    bit_s   = {BW{1'b0}};
                    cs_s    = 1'b0;
                    sda_s   = head_data_s[DATA_WIDTH-1];
                    state_s = S_SETUP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SETUP: begin
                if (phase_end_s) begin
                    ph_s    = {DIV_WIDTH{1'b0}};
                    scl_s   = 1'b0;
                    state_s = S_LOW;
                end else begin
                    state_s = S_SETUP;
                end
            end
            S_LOW: begin
                if (phase_end_s) begin
                    ph_s    = {DIV_WIDTH{1'b0}};
                    scl_s   = 1'b1;
                    state_s = S_HIGH;
                end else begin
                    state_s = S_LOW;
                end
            end
            S_HIGH: begin
                if (!phase_end_s) begin
                    state_s = S_HIGH;
                end else if (bit_r != BW'(DATA_WIDTH - 1)) begin
                    ph_s    = {DIV_WIDTH{1'b0}};
                    bit_s   = bit_r + BW'(1);
                    sh_s    = {sh_r[DATA_WIDTH-2:0], 1'b0};
                    sda_s   = sh_r[DATA_WIDTH-2];
                    scl_s   = 1'b0;
                    state_s = S_LOW;
                end else begin
                    ph_s   = {DIV_WIDTH{1'b0}};
                    done_s = 1'b1;
                    // Burst continues only when the next word is already queued
                    if (!last_r && !empty_s) begin
                        pop_s   = 1'b1;
                        sh_s    = head_data_s;
                        last_s  = head_last_s;
                        hdiv_s  = div;
                        rs_s    = head_rs_s;
                        bit_s   = {BW{1'b0}};
                        sda_s   = head_data_s[DATA_WIDTH-1];
                        scl_s   = 1'b0;
                        state_s = S_LOW;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (phase_end_s) begin
                    ph_s    = {DIV_WIDTH{1'b0}};
                    cs_s    = 1'b1;
                    sda_s   = 1'b1;
                    state_s = S_GAP;
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_GAP: begin
                if (phase_end_s) begin
                    ph_s    = {DIV_WIDTH{1'b0}};
                    state_s = S_IDLE;
                end else begin
                    state_s = S_GAP;
                end
            end
            default: begin
                ph_s    = {DIV_WIDTH{1'b0}};
                cs_s    = 1'b1;
                scl_s   = 1'b1;
                sda_s   = 1'b1;
                state_s = S_IDLE;
            end
        endcase
    end

    // FSM, shifter and SPI pin registers; reset drops any word in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            ph_r    <= {DIV_WIDTH{1'b0}};
            hdiv_r  <= {DIV_WIDTH{1'b0}};
            bit_r   <= {BW{1'b0}};
            sh_r    <= {DATA_WIDTH{1'b0}};
            last_r  <= 1'b0;
            cs_r    <= 1'b1;
            scl_r   <= 1'b1;
            sda_r   <= 1'b1;
            rs_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ph_r    <= ph_s;
            hdiv_r  <= hdiv_s;
            bit_r   <= bit_s;
            sh_r    <= sh_s;
            last_r  <= last_s;
            cs_r    <= cs_s;
            scl_r   <= scl_s;
            sda_r   <= sda_s;
            rs_r    <= rs_s;
            done_r  <= done_s;
        end
    end

    // Panel reset and backlight pins; reset itself forces the panel into reset
    always_ff @(posedge clk) begin
        rst_lcd_r <= ~(rst | lcd_rst_req);
        led_lcd_r <= led_en & ~rst;
    end

    assign in_ready   = ~full_s;
    assign fifo_level = count_r;
    assign busy       = (state_r != S_IDLE) | ~empty_s;
    assign done       = done_r;
    assign cs_lcd     = cs_r;
    assign scl_lcd    = scl_r;
    assign sda_lcd    = sda_r;
    assign rs_lcd     = rs_r;
    assign rst_lcd    = rst_lcd_r;
    assign led_lcd    = led_lcd_r;

endmodule
